// File: rtl/lsu_pkg.sv
// lsu_pkg: shared MemOp encodings, FSM states and access-size decode for the LSU.
package lsu_pkg;
   typedef enum logic [2:0] {
      OP_B  = 3'b000,
      OP_H  = 3'b001,
      OP_W  = 3'b010,
      OP_D  = 3'b011,
      OP_BU = 3'b100,
      OP_HU = 3'b101,
      OP_WU = 3'b110
   } mem_op_t;
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_REQ2, S_WAIT2} state_t;
   function automatic logic [3:0] op_bytes(input logic [2:0] op);
      return 4'd1 << op[1:0];
   endfunction
   // Dword and unsigned-word only exist on a 64-bit core; 3'b111 is never legal.
   function automatic logic op_legal(input logic [2:0] op, input int xlen);
      return (op == OP_D || op == OP_WU) ? (xlen == 64) : (op != 3'b111);
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: lane positioning of store data/mask over a two-word window, and
// right-shift plus sign/zero extension of load data from the same window.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [$clog2(XLEN/8)-1:0] i_off,
   input  logic [2:0]                i_op,
   input  logic [XLEN-1:0]           i_wdata,
   input  logic [2*XLEN-1:0]         i_rdata,
   output logic [2*XLEN-1:0]         o_wdata,
   output logic [XLEN/4-1:0]         o_wmask,
   output logic [XLEN-1:0]           o_rdata
);
   logic [3:0] w_size;
   logic [XLEN-1:0] w_sh, w_keep, w_top;
   logic w_sign;
   // w_keep wraps to all ones for a full-width access, so no special case is needed.
   always_comb begin
      w_size = op_bytes(i_op);
      o_wmask = (XLEN/4)'((16'd1 << w_size) - 16'd1) << i_off;
      o_wdata = {{XLEN{1'b0}}, i_wdata} << {i_off, 3'b000};
      w_sh = XLEN'(i_rdata >> {i_off, 3'b000});
      w_keep = (XLEN'(1) << {w_size, 3'b000}) - XLEN'(1);
      w_top = w_keep ^ (w_keep >> 1);
      w_sign = !i_op[2] && |(w_sh & w_top);
      o_rdata = (w_sh & w_keep) | ({XLEN{w_sign}} & ~w_keep);
   end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit bridging a core request/response port to a single-beat
// bus, optionally splitting word-crossing misaligned accesses into two beats.
module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ADDR_W = 32,
   parameter int ALLOW_MISALIGN = 0
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_mem_wr,
   input  logic [2:0]        i_mem_op,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [XLEN-1:0]   i_wdata,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [XLEN-1:0]   o_rdata,
   output logic              o_resp_err,
   output logic              o_bus_req,
   input  logic              i_bus_gnt,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic              o_bus_we,
   output logic [XLEN-1:0]   o_bus_wdata,
   output logic [XLEN/8-1:0] o_bus_wmask,
   input  logic              i_bus_rvalid,
   input  logic [XLEN-1:0]   i_bus_rdata
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   state_t r_state, w_next;
   logic r_wr, r_split, r_err;
   logic [2:0] r_op;
   logic [ADDR_W-1:0] r_addr, w_addr1, w_addr2;
   logic [XLEN-1:0] r_wdata, r_lo, r_rdata, w_ext;
   logic [2*XLEN-1:0] w_wd2, w_rd2;
   logic [2*NB-1:0] w_wm2;
   logic [3:0] w_in_size;
   logic w_hs, w_in_unal, w_in_err, w_in_split, w_req, w_st, w_beat2;

   always_comb begin
      w_hs = i_req_valid && r_state == S_IDLE;
      w_in_size = op_bytes(i_mem_op);
      w_in_unal = (4'(i_addr[OW-1:0]) & (w_in_size - 4'd1)) != 4'd0;
      w_in_split = ALLOW_MISALIGN != 0 && 5'(i_addr[OW-1:0]) + 5'(w_in_size) > 5'(NB);
      w_in_err = !op_legal(i_mem_op, XLEN) || (ALLOW_MISALIGN == 0 && w_in_unal);
      w_addr1 = {r_addr[ADDR_W-1:OW], {OW{1'b0}}};
      w_addr2 = w_addr1 + ADDR_W'(NB);
      w_rd2 = r_state == S_WAIT2 ? {i_bus_rdata, r_lo} : {{XLEN{1'b0}}, i_bus_rdata};
   end

   lsu_align #(.XLEN(XLEN)) u_align (
      .i_off(r_addr[OW-1:0]),
      .i_op(r_op),
      .i_wdata(r_wdata),
      .i_rdata(w_rd2),
      .o_wdata(w_wd2),
      .o_wmask(w_wm2),
      .o_rdata(w_ext)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rstn) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_hs ? (w_in_err ? S_RESP : S_REQ) : S_IDLE;
         S_REQ:   w_next = !i_bus_gnt ? S_REQ : !r_wr ? S_WAIT : r_split ? S_REQ2 : S_RESP;
         S_WAIT:  w_next = !i_bus_rvalid ? S_WAIT : r_split ? S_REQ2 : S_RESP;
         S_REQ2:  w_next = !i_bus_gnt ? S_REQ2 : r_wr ? S_RESP : S_WAIT2;
         S_WAIT2: w_next = i_bus_rvalid ? S_RESP : S_WAIT2;
         S_RESP:  w_next = i_resp_ready ? S_IDLE : S_RESP;
         default: w_next = S_IDLE;
      endcase
      w_req = r_state == S_REQ || r_state == S_REQ2;
      w_st = w_req && r_wr;
      w_beat2 = r_state == S_REQ2;
      o_req_ready = r_state == S_IDLE;
      o_resp_valid = r_state == S_RESP;
      o_resp_err = r_err;
      o_rdata = r_rdata;
      o_bus_req = w_req;
      o_bus_we = w_st;
      o_bus_addr = !w_req ? '0 : w_beat2 ? w_addr2 : w_addr1;
      o_bus_wdata = !w_st ? '0 : w_beat2 ? w_wd2[2*XLEN-1:XLEN] : w_wd2[XLEN-1:0];
      o_bus_wmask = !w_st ? '0 : w_beat2 ? w_wm2[2*NB-1:NB] : w_wm2[NB-1:0];
   end

   // Beat-1 read data is parked in r_lo until beat 2 arrives for the merge.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_wr <= 1'b0;
         r_op <= '0;
         r_addr <= '0;
         r_wdata <= '0;
         r_split <= 1'b0;
         r_err <= 1'b0;
         r_lo <= '0;
         r_rdata <= '0;
      end else begin
         if (w_hs) begin
            r_wr <= i_mem_wr;
            r_op <= i_mem_op;
            r_addr <= i_addr;
            r_wdata <= i_wdata;
            r_split <= w_in_split;
            r_err <= w_in_err;
            r_rdata <= '0;
         end
         if (r_state == S_WAIT && i_bus_rvalid) r_lo <= i_bus_rdata;
         if (i_bus_rvalid && ((r_state == S_WAIT && !r_split) || r_state == S_WAIT2)) r_rdata <= w_ext;
      end
   end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu over three builds: 32-bit strict (a),
// 32-bit split-misaligned (m) and 64-bit strict (w), sharing stimulus lines.
module tb_lsu;
   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0, rstn = 1'b0;
   logic [2:0] rv = '0;
   logic wr = 1'b0, resp_ready = 1'b0, gnt = 1'b0, rvalid = 1'b0;
   logic [2:0] op = '0;
   logic [31:0] addr = '0;
   logic [63:0] wd = '0, brd = '0;
   logic a_ready, a_rv, a_err, a_breq, a_bwe, m_ready, m_rv, m_err, m_breq, m_bwe;
   logic w_ready, w_rv, w_err, w_breq, w_bwe;
   logic [31:0] a_rdata, a_baddr, a_bwd, m_rdata, m_baddr, m_bwd, w_baddr;
   logic [63:0] w_rdata, w_bwd;
   logic [3:0] a_bwm, m_bwm;
   logic [7:0] w_bwm;
   logic g_ready, g_rv, g_err;
   logic [63:0] g_rdata;
   logic [127:0] g_bus;
   exp_t q[$];
   int n_chk = 0, n_fail = 0, sel = 0, breq_cnt = 0, nb = 0;

   always #5 clk = ~clk;

   lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGN(0)) u_a (
      .i_clk(clk), .i_rstn(rstn), .i_req_valid(rv[0]), .o_req_ready(a_ready),
      .i_mem_wr(wr), .i_mem_op(op), .i_addr(addr), .i_wdata(wd[31:0]),
      .o_resp_valid(a_rv), .i_resp_ready(resp_ready), .o_rdata(a_rdata), .o_resp_err(a_err),
      .o_bus_req(a_breq), .i_bus_gnt(gnt), .o_bus_addr(a_baddr), .o_bus_we(a_bwe),
      .o_bus_wdata(a_bwd), .o_bus_wmask(a_bwm), .i_bus_rvalid(rvalid), .i_bus_rdata(brd[31:0])
   );
   lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGN(1)) u_m (
      .i_clk(clk), .i_rstn(rstn), .i_req_valid(rv[1]), .o_req_ready(m_ready),
      .i_mem_wr(wr), .i_mem_op(op), .i_addr(addr), .i_wdata(wd[31:0]),
      .o_resp_valid(m_rv), .i_resp_ready(resp_ready), .o_rdata(m_rdata), .o_resp_err(m_err),
      .o_bus_req(m_breq), .i_bus_gnt(gnt), .o_bus_addr(m_baddr), .o_bus_we(m_bwe),
      .o_bus_wdata(m_bwd), .o_bus_wmask(m_bwm), .i_bus_rvalid(rvalid), .i_bus_rdata(brd[31:0])
   );
   lsu #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGN(0)) u_w (
      .i_clk(clk), .i_rstn(rstn), .i_req_valid(rv[2]), .o_req_ready(w_ready),
      .i_mem_wr(wr), .i_mem_op(op), .i_addr(addr), .i_wdata(wd),
      .o_resp_valid(w_rv), .i_resp_ready(resp_ready), .o_rdata(w_rdata), .o_resp_err(w_err),
      .o_bus_req(w_breq), .i_bus_gnt(gnt), .o_bus_addr(w_baddr), .o_bus_we(w_bwe),
      .o_bus_wdata(w_bwd), .o_bus_wmask(w_bwm), .i_bus_rvalid(rvalid), .i_bus_rdata(brd)
   );

   function automatic logic [127:0] bf(input logic r, input logic w, input logic [7:0] m,
                                       input logic [31:0] a, input logic [63:0] d);
      return {22'd0, r, w, m, a, d};
   endfunction

   always_comb begin
      g_ready = sel == 0 ? a_ready : sel == 1 ? m_ready : w_ready;
      g_rv = sel == 0 ? a_rv : sel == 1 ? m_rv : w_rv;
      g_err = sel == 0 ? a_err : sel == 1 ? m_err : w_err;
      g_rdata = sel == 0 ? 64'(a_rdata) : sel == 1 ? 64'(m_rdata) : w_rdata;
      g_bus = sel == 0 ? bf(a_breq, a_bwe, 8'(a_bwm), a_baddr, 64'(a_bwd))
            : sel == 1 ? bf(m_breq, m_bwe, 8'(m_bwm), m_baddr, 64'(m_bwd))
            : bf(w_breq, w_bwe, w_bwm, w_baddr, w_bwd);
   end

   always @(posedge clk) if (a_breq) breq_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input int s, input logic w_, input logic [2:0] o, input logic [31:0] ad,
                        input logic [63:0] d, input bit exp_v, input logic [63:0] e_rd, input logic e_err);
      sel = s;
      wr = w_;
      op = o;
      addr = ad;
      wd = d;
      rv[s] = 1'b1;
      if (exp_v) q.push_back('{rdata: e_rd, err: e_err});
      step();
      rv = '0;
   endtask

   task automatic get_resp(input string tag);
      exp_t e;
      int n = 0;
      while (g_rv !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_valid"}, 128'(g_rv), 128'(1));
      chk({tag, "_sb"}, 128'(q.size()), 128'(1));
      if (q.size() != 0) begin
         e = q.pop_front();
         chk({tag, "_rdata"}, 128'(g_rdata), 128'(e.rdata));
         chk({tag, "_err"}, 128'(g_err), 128'(e.err));
         step();
         chk({tag, "_hold"}, 128'({g_rv, g_err, g_rdata}), 128'({1'b1, e.err, e.rdata}));
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk({tag, "_idle"}, 128'({g_ready, g_rv}), 128'(2'b10));
   endtask

   task automatic load_once(input int s, input logic [2:0] o, input logic [31:0] ad, input logic [63:0] rd,
                            input logic [31:0] eaddr, input logic [63:0] exp, input string tag);
      issue(s, 1'b0, o, ad, 64'd0, 1'b1, exp, 1'b0);
      chk({tag, "_bus"}, g_bus, bf(1'b1, 1'b0, 8'd0, eaddr, 64'd0));
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      rvalid = 1'b1;
      brd = rd;
      step();
      rvalid = 1'b0;
      chk({tag, "_lat3"}, 128'(g_rv), 128'(1));
      get_resp(tag);
   endtask

   task automatic store_once(input int s, input logic [2:0] o, input logic [31:0] ad, input logic [63:0] d,
                             input logic [31:0] eaddr, input logic [7:0] emask, input logic [63:0] edata,
                             input string tag);
      issue(s, 1'b1, o, ad, d, 1'b1, 64'd0, 1'b0);
      chk({tag, "_bus"}, g_bus, bf(1'b1, 1'b1, emask, eaddr, edata));
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      chk({tag, "_lat2"}, 128'(g_rv), 128'(1));
      get_resp(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      step();
      step();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk($sformatf("rst%0d_bus", s), g_bus, 128'd0);
         chk($sformatf("rst%0d_resp", s), 128'({g_ready, g_rv, g_err, g_rdata}), 128'({1'b1, 66'd0}));
      end
      rstn = 1'b1;
      step();
      // Aligned and sub-word loads on the strict 32-bit build.
      load_once(0, 3'b000, 32'h1003, 64'h80FFFFFF, 32'h1000, 64'hFFFFFF80, "lb_neg");
      load_once(0, 3'b100, 32'h1003, 64'h80FFFFFF, 32'h1000, 64'h80, "lbu");
      load_once(0, 3'b000, 32'h1001, 64'h00007F00, 32'h1000, 64'h7F, "lb_pos");
      load_once(0, 3'b001, 32'h1002, 64'h80011234, 32'h1000, 64'hFFFF8001, "lh_neg");
      load_once(0, 3'b101, 32'h1006, 64'h80011234, 32'h1004, 64'h8001, "lhu");
      load_once(0, 3'b010, 32'h1008, 64'hCAFEF00D, 32'h1008, 64'hCAFEF00D, "lw");
      // Store held across a late grant.
      issue(0, 1'b1, 3'b001, 32'h2002, 64'hBEEF, 1'b1, 64'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("sh_wait%0d", i), g_bus, bf(1'b1, 1'b1, 8'hC, 32'h2000, 64'hBEEF0000));
         step();
      end
      gnt = 1'b1;
      chk("sh_gnt", g_bus, bf(1'b1, 1'b1, 8'hC, 32'h2000, 64'hBEEF0000));
      step();
      gnt = 1'b0;
      chk("sh_bus_off", g_bus, 128'd0);
      chk("sh_lat", 128'(g_rv), 128'(1));
      get_resp("sh");
      store_once(0, 3'b000, 32'h2001, 64'hFFFFFF5A, 32'h2000, 8'h2, 64'hFFFF5A00, "sb");
      store_once(0, 3'b010, 32'h2004, 64'h12345678, 32'h2004, 8'hF, 64'h12345678, "sw");
      // Misaligned and illegal codes: immediate error, no bus cycle.
      for (int i = 0; i < 5; i++) begin
         logic [2:0] eo;
         logic [31:0] ea;
         eo = i == 0 ? 3'b010 : i == 1 ? 3'b001 : i == 2 ? 3'b011 : i == 3 ? 3'b110 : 3'b111;
         ea = i < 2 ? 32'h3001 + 32'(2 * i) : 32'h3000;
         nb = breq_cnt;
         issue(0, 1'b0, eo, ea, 64'd0, 1'b1, 64'd0, 1'b1);
         chk($sformatf("err%0d_lat1", i), 128'(g_rv), 128'(1));
         get_resp($sformatf("err%0d", i));
         chk($sformatf("err%0d_nobus", i), 128'(breq_cnt - nb), 128'd0);
      end
      // Split store on the misalign build.
      issue(1, 1'b1, 3'b010, 32'h4003, 64'h11223344, 1'b1, 64'd0, 1'b0);
      chk("ss_beat1", g_bus, bf(1'b1, 1'b1, 8'h8, 32'h4000, 64'h44000000));
      gnt = 1'b1;
      step();
      chk("ss_beat2", g_bus, bf(1'b1, 1'b1, 8'h7, 32'h4004, 64'h00112233));
      step();
      gnt = 1'b0;
      chk("ss_lat", 128'(g_rv), 128'(1));
      get_resp("ss");
      // Split load; a stray rvalid during beat-2 request must be ignored.
      issue(1, 1'b0, 3'b010, 32'h4003, 64'd0, 1'b1, 64'h887766AA, 1'b0);
      chk("sl_beat1", g_bus, bf(1'b1, 1'b0, 8'd0, 32'h4000, 64'd0));
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      rvalid = 1'b1;
      brd = 64'hAABBCCDD;
      step();
      brd = 64'hDEADBEEF;
      chk("sl_beat2", g_bus, bf(1'b1, 1'b0, 8'd0, 32'h4004, 64'd0));
      step();
      chk("sl_beat2_hold", g_bus, bf(1'b1, 1'b0, 8'd0, 32'h4004, 64'd0));
      rvalid = 1'b0;
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      rvalid = 1'b1;
      brd = 64'h99887766;
      step();
      rvalid = 1'b0;
      get_resp("sl");
      load_once(1, 3'b001, 32'h4001, 64'h00800100, 32'h4000, 64'hFFFF8001, "lh_inword");
      // 64-bit build.
      load_once(2, 3'b110, 32'h5004, 64'hFFFFFFFF_00000000, 32'h5000, 64'h00000000_FFFFFFFF, "lwu64");
      load_once(2, 3'b010, 32'h5004, 64'hFFFFFFFF_00000000, 32'h5000, 64'hFFFFFFFF_FFFFFFFF, "lw64");
      load_once(2, 3'b011, 32'h5008, 64'h81234567_89ABCDEF, 32'h5008, 64'h81234567_89ABCDEF, "ld64");
      store_once(2, 3'b000, 32'h5005, 64'hA5, 32'h5000, 8'h20, 64'h0000A500_00000000, "sb64");
      store_once(2, 3'b011, 32'h5008, 64'h01234567_89ABCDEF, 32'h5008, 8'hFF, 64'h01234567_89ABCDEF, "sd64");
      // Reset while waiting for read data, then a late rvalid.
      issue(0, 1'b0, 3'b010, 32'h6000, 64'd0, 1'b0, 64'd0, 1'b0);
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      rvalid = 1'b1;
      brd = 64'h1234;
      step();
      rvalid = 1'b0;
      chk("late_rvalid", 128'({g_ready, g_rv}), 128'(2'b10));
      step();
      step();
      chk("late_quiet", 128'({g_ready, g_rv, g_bus}), 128'({2'b10, 128'd0}));
      load_once(0, 3'b010, 32'h6000, 64'h5555AAAA, 32'h6000, 64'h5555AAAA, "post_rst");
      chk("sb_empty", 128'(q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
